sobel_window_assembler: RTL
===========================

Name: sobel_window_assembler

Overview:
- Consumer-side partner of the line delay buffer in the Sobel pipeline.
- Takes the current-row pixel and the two row-delayed taps as one valid/ready stream, shifts them into a 3x3 register window, and tracks raster column/row position.
- Emits only fully interior 3x3 windows, plus center coordinates and frame markers, to the gradient stage.
- One-deep elastic output stage.

Parameters:
- WIDTH_P, 8, pixel width in bits
- LINE_W_P, 640, pixels per line (>= 3)
- LINE_H_P, 480, lines per frame (>= 3)

Ports:
- clk_i  input  1  clock; all state on rising edge
- rstn_i  input  1  reset; one clock; reset is asynchronous and active-low
- valid_i  input  1  input column valid
- ready_o  output  1  input column accepted when valid_i & ready_o
- data_row0_i  input  WIDTH_P  current-row pixel (bottom of window)
- data_row1_i  input  WIDTH_P  pixel one line above
- data_row2_i  input  WIDTH_P  pixel two lines above (top of window)
- valid_o  output  1  window valid
- ready_i  input  1  downstream ready
- win_o  output  9*WIDTH_P  window, element (r,c) at [(r*3+c)*WIDTH_P +: WIDTH_P]; r=0 top, c=0 oldest/left; center is index 4
- x_o  output  $clog2(LINE_W_P)  window center column
- y_o  output  $clog2(LINE_H_P)  window center row
- sof_o  output  1  first window of frame, center (1,1)
- eof_o  output  1  last window of frame, center (LINE_W_P-2, LINE_H_P-2)

Behaviour:
- Reset values: valid_o=0, win_o=0, x_o=0, y_o=0, sof_o=0, eof_o=0, col counter=0, row counter=0.
- ready_o is combinational: ready_o = !valid_o | ready_i.
- accept = valid_i & ready_o.

On accept:
- Columns shift left: c0<=c1, c1<=c2.
- c2 <= {data_row2_i, data_row1_i, data_row0_i} for rows 0, 1, 2.
- valid_o <= (col >= 2) && (row >= 2), using the counters before increment.
- x_o <= col-1, y_o <= row-1.
- sof_o <= (col==2 && row==2).
- eof_o <= (col==LINE_W_P-1 && row==LINE_H_P-1).

Counters, advancing on accept only:
- col increments and wraps LINE_W_P-1 -> 0.
- On col wrap, row increments and wraps LINE_H_P-1 -> 0 (frame boundary).
- No external sync: frame alignment comes from reset only.

Without accept:
- If ready_i, valid_o <= 0.
- Otherwise all outputs hold.

Latency and stall rules:
- Accepted column at cycle N appears in win_o c2 at cycle N+1.
- While valid_o=1 and ready_i=0: ready_o=0, and win_o, x_o, y_o, sof_o, eof_o are stable.
- Simultaneous output drain and input accept in one cycle gives full throughput, 1 window/cycle.
- Non-interior inputs (col<2 or row<2) are consumed silently, with valid_o=0 for that slot; the window still shifts.
- At line start, c0/c1 hold the previous line's tail; col<2 gating discards these windows.
- Windows per frame = (LINE_W_P-2)*(LINE_H_P-2).
- Async reset mid-frame clears counters and valid_o immediately. The next accepted input is treated as (0,0); any in-flight window is dropped.
- Arithmetic: counters are unsigned, sized $clog2(LINE_W_P) and $clog2(LINE_H_P); no overflow beyond wrap.

Test Plan:
1. Basic 4x4 frame. LINE_W_P=4, LINE_H_P=4; pixel p=row*4+col; row0=p, row1=p-4, row2=p-8; ready_i=1. Require:
   - Exactly 4 windows.
   - First window has win_o = top {0,1,2}, mid {4,5,6}, bottom {8,9,10}, x_o=1, y_o=1, sof_o=1.
   - Last window has center 10, x_o=2, y_o=2, eof_o=1.
2. Gating, same frame. Require valid_o=0 after each of the first 10 accepts and ready_o=1 throughout.
3. Backpressure. Hold ready_i=0 for 5 cycles while the first window is valid. Require:
   - ready_o=0 and win_o/x_o/y_o unchanged.
   - After release, the window drains and the next input is accepted the same cycle.
4. Bubbles. Toggle valid_i randomly across a 5x4 frame. Require:
   - 6 windows in raster order with centers (1,1),(2,1),(3,1),(1,2),(2,2),(3,2), content matching the model.
   - No window emitted without an accept.
5. Frame wrap. Two back-to-back 4x4 frames. Require sof_o on the 5th window with x_o=1, y_o=1, and 8 windows in total.
6. Reset mid-frame. Assert rstn_i low after 7 accepts. Require:
   - valid_o=0 immediately.
   - A subsequent clean frame produces the same outputs as scenario 1.

Source files
------------

// File: rtl/sobel_window_assembler.sv
// 3x3 window assembler for the Sobel pipeline: shifts column triples from the
// line delay buffer into a register window and emits interior windows only.
module sobel_window_assembler #(
    parameter int WIDTH_P  = 8,
    parameter int LINE_W_P = 640,
    parameter int LINE_H_P = 480
) (
    input  logic                          clk_i,
    input  logic                          rstn_i,
    input  logic                          valid_i,
    output logic                          ready_o,
    input  logic [WIDTH_P-1:0]            data_row0_i,
    input  logic [WIDTH_P-1:0]            data_row1_i,
    input  logic [WIDTH_P-1:0]            data_row2_i,
    output logic                          valid_o,
    input  logic                          ready_i,
    output logic [9*WIDTH_P-1:0]          win_o,
    output logic [$clog2(LINE_W_P)-1:0]   x_o,
    output logic [$clog2(LINE_H_P)-1:0]   y_o,
    output logic                          sof_o,
    output logic                          eof_o
);

    localparam int XW = $clog2(LINE_W_P);
    localparam int YW = $clog2(LINE_H_P);

    localparam logic [XW-1:0] COL_ONE  = XW'(1);
    localparam logic [XW-1:0] COL_TWO  = XW'(2);
    localparam logic [XW-1:0] COL_LAST = XW'(LINE_W_P - 1);
    localparam logic [YW-1:0] ROW_ONE  = YW'(1);
    localparam logic [YW-1:0] ROW_TWO  = YW'(2);
    localparam logic [YW-1:0] ROW_LAST = YW'(LINE_H_P - 1);

    logic                 r_valid;
    logic [9*WIDTH_P-1:0] r_win;
    logic [XW-1:0]        r_x;
    logic [YW-1:0]        r_y;
    logic                 r_sof;
    logic                 r_eof;
    logic [XW-1:0]        r_col;
    logic [YW-1:0]        r_row;

    logic                 w_accept;
    logic                 w_col_last;
    logic                 w_row_last;
    logic                 w_interior;
    logic [9*WIDTH_P-1:0] w_win_next;

    assign ready_o    = ~r_valid | ready_i;
    assign w_accept   = valid_i & ready_o;
    assign w_col_last = (r_col == COL_LAST);
    assign w_row_last = (r_row == ROW_LAST);
    assign w_interior = (r_col >= COL_TWO) && (r_row >= ROW_TWO);

    assign valid_o = r_valid;
    assign win_o   = r_win;
    assign x_o     = r_x;
    assign y_o     = r_y;
    assign sof_o   = r_sof;
    assign eof_o   = r_eof;

    // Window after one left shift: oldest column drops out, new triple enters at c2.
    always_comb begin
        w_win_next = r_win;
        for (int r = 0; r < 3; r++) begin
            w_win_next[(r*3+0)*WIDTH_P +: WIDTH_P] = r_win[(r*3+1)*WIDTH_P +: WIDTH_P];
            w_win_next[(r*3+1)*WIDTH_P +: WIDTH_P] = r_win[(r*3+2)*WIDTH_P +: WIDTH_P];
        end
        // Top row of the window is the oldest line (two lines above).
        w_win_next[2*WIDTH_P +: WIDTH_P] = data_row2_i;
        w_win_next[5*WIDTH_P +: WIDTH_P] = data_row1_i;
        w_win_next[8*WIDTH_P +: WIDTH_P] = data_row0_i;
    end

    // Raster counters plus the one-deep output register.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_valid <= 1'b0;
            r_win   <= '0;
            r_x     <= '0;
            r_y     <= '0;
            r_sof   <= 1'b0;
            r_eof   <= 1'b0;
            r_col   <= '0;
            r_row   <= '0;
        end else if (w_accept) begin
            r_win   <= w_win_next;
            r_valid <= w_interior;
            r_x     <= r_col - COL_ONE;
            r_y     <= r_row - ROW_ONE;
            r_sof   <= (r_col == COL_TWO) && (r_row == ROW_TWO);
            r_eof   <= w_col_last && w_row_last;
            if (w_col_last) begin
                r_col <= '0;
                r_row <= w_row_last ? '0 : r_row + ROW_ONE;
            end else begin
                r_col <= r_col + COL_ONE;
            end
        end else if (ready_i) begin
            r_valid <= 1'b0;
        end
    end

endmodule
